pipeline_ctrl: RTL and testbench

Central stall/flush controller for the five-stage MIPS pipeline. Drives the enable and synchronous-clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable. It owns the multiply/divide busy sequencer and detects three conditions:
- load-use hazards;
- branch-in-ID hazards;
- MDU-busy hazards.

It also flushes the pipeline when an exception or ERET is taken at MEM.

---
 rtl/pipeline_ctrl_pkg.sv | 26 ++
 rtl/pipeline_ctrl_if.sv | 44 ++++
 rtl/pipeline_ctrl_md_busy_counter.sv | 48 ++++
 rtl/pipeline_ctrl.sv | 75 +++++++
 tb/tb_pipeline_ctrl.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller:
// MD op encodings, MD sequencer states and default MDU latencies.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MULT = 2'b01,
    MD_DIV  = 2'b10,
    MD_RSVD = 2'b11
  } md_op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 4;

  // $0 is hardwired, so a write to it can never create a dependency.
  function automatic logic reg_hit(input logic [4:0] wr_reg, input logic [4:0] src_reg);
    return (wr_reg != 5'd0) && (wr_reg == src_reg);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-detection inputs and pipeline-register control outputs of the
// stall/flush controller, bundled for connection to the datapath.
interface pipeline_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_branch;
  logic       id_md_use;
  logic       ex_reg_write;
  logic       ex_load;
  logic [4:0] ex_wr_reg;
  logic       mem_load;
  logic [4:0] mem_wr_reg;
  logic [1:0] ex_md_op;
  logic       mem_exc;
  logic       pc_en;
  logic       en_ifid;
  logic       en_idex;
  logic       en_exmem;
  logic       en_memwb;
  logic       clr_ifid;
  logic       clr_idex;
  logic       clr_exmem;
  logic       clr_memwb;
  logic       md_start;
  logic       md_busy;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_md_use,
           ex_reg_write, ex_load, ex_wr_reg, mem_load, mem_wr_reg,
           ex_md_op, mem_exc,
    input  pc_en, en_ifid, en_idex, en_exmem, en_memwb,
           clr_ifid, clr_idex, clr_exmem, clr_memwb, md_start, md_busy
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_md_use,
           ex_reg_write, ex_load, ex_wr_reg, mem_load, mem_wr_reg,
           ex_md_op, mem_exc,
    output pc_en, en_ifid, en_idex, en_exmem, en_memwb,
           clr_ifid, clr_idex, clr_exmem, clr_memwb, md_start, md_busy
  );
endinterface

// File: rtl/pipeline_ctrl_md_busy_counter.sv
// Multiply/divide busy sequencer: counts down the MDU latency after a start.
//   state   | meaning
//   ST_RUN  | MDU idle, result valid, ready to accept a start
//   ST_BUSY | MDU computing, cnt = cycles remaining until result valid
module md_busy_counter
  import pipeline_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] load_cnt,
  output logic             busy
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (start) begin
          cnt_d   = load_cnt;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign busy = (state_q == ST_BUSY);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the five-stage pipeline: hazard
// detection, exception flush and pipeline-register enable/clear generation.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           reset,
  pipeline_ctrl_if.slave bus
);

  logic             stall_ld;
  logic             stall_br;
  logic             stall_md;
  logic             stall;
  logic             is_mult;
  logic             is_div;
  logic             md_start;
  logic             md_busy;
  logic [CNT_W-1:0] load_cnt;

  always_comb begin
    stall_ld = bus.ex_load &&
               ((bus.id_use_rs && reg_hit(bus.ex_wr_reg, bus.id_rs)) ||
                (bus.id_use_rt && reg_hit(bus.ex_wr_reg, bus.id_rt)));
    // Branches resolve in ID, so any EX write or MEM load is still too late to forward.
    stall_br = bus.id_branch &&
               ((bus.ex_reg_write && (reg_hit(bus.ex_wr_reg, bus.id_rs) ||
                                      reg_hit(bus.ex_wr_reg, bus.id_rt))) ||
                (bus.mem_load     && (reg_hit(bus.mem_wr_reg, bus.id_rs) ||
                                      reg_hit(bus.mem_wr_reg, bus.id_rt))));
    is_mult  = (bus.ex_md_op == MD_MULT);
    is_div   = (bus.ex_md_op == MD_DIV);
    md_start = (is_mult || is_div) && !md_busy && !bus.mem_exc;
    load_cnt = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    stall_md = bus.id_md_use && (md_busy || md_start);
    stall    = stall_ld || stall_br || stall_md;
  end

  md_busy_counter u_md_busy_counter (
    .clk      (clk),
    .reset    (reset),
    .start    (md_start),
    .load_cnt (load_cnt),
    .busy     (md_busy)
  );

  always_comb begin
    bus.pc_en     = 1'b1;
    bus.en_ifid   = 1'b1;
    bus.en_idex   = 1'b1;
    bus.en_exmem  = 1'b1;
    bus.en_memwb  = 1'b1;
    bus.clr_ifid  = 1'b0;
    bus.clr_idex  = 1'b0;
    bus.clr_exmem = 1'b0;
    bus.clr_memwb = 1'b0;
    // MEM/WB is left alone on a flush; the exception unit squashes MEM itself.
    if (bus.mem_exc) begin
      bus.clr_ifid  = 1'b1;
      bus.clr_idex  = 1'b1;
      bus.clr_exmem = 1'b1;
    end else if (stall) begin
      bus.pc_en    = 1'b0;
      bus.en_ifid  = 1'b0;
      bus.clr_idex = 1'b1;
    end
  end

  assign bus.md_start = md_start;
  assign bus.md_busy  = md_busy;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by random
// stimulus, compared against a cycle-numbered behavioural model.
module tb_pipeline_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   busy_end = -1;
  logic [10:0] obs;
  logic [10:0] exp_v;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected {pc_en,en_ifid,en_idex,en_exmem,en_memwb,clr_ifid,clr_idex,clr_exmem,clr_memwb,md_start,md_busy}
  function automatic logic [10:0] model(output bit start_o);
    bit busy, ld, br, md, st, ex_dep, mem_dep;
    busy    = (cyc <= busy_end);
    ld      = bus.ex_load && bus.ex_wr_reg != 0 &&
              ((bus.id_use_rs && bus.id_rs == bus.ex_wr_reg) ||
               (bus.id_use_rt && bus.id_rt == bus.ex_wr_reg));
    ex_dep  = bus.ex_reg_write && bus.ex_wr_reg != 0 &&
              (bus.ex_wr_reg == bus.id_rs || bus.ex_wr_reg == bus.id_rt);
    mem_dep = bus.mem_load && bus.mem_wr_reg != 0 &&
              (bus.mem_wr_reg == bus.id_rs || bus.mem_wr_reg == bus.id_rt);
    br      = bus.id_branch && (ex_dep || mem_dep);
    start_o = (bus.ex_md_op == 2'd1 || bus.ex_md_op == 2'd2) && !busy && !bus.mem_exc;
    md      = bus.id_md_use && (busy || start_o);
    st      = ld || br || md;
    if (bus.mem_exc)
      return {5'b11111, 4'b1110, start_o, busy};
    else if (st)
      return {5'b00111, 4'b0100, start_o, busy};
    else
      return {5'b11111, 4'b0000, start_o, busy};
  endfunction

  task automatic set_idle();
    bus.id_rs = 0; bus.id_rt = 0; bus.id_use_rs = 0; bus.id_use_rt = 0;
    bus.id_branch = 0; bus.id_md_use = 0; bus.ex_reg_write = 0; bus.ex_load = 0;
    bus.ex_wr_reg = 0; bus.mem_load = 0; bus.mem_wr_reg = 0; bus.ex_md_op = 0;
    bus.mem_exc = 0;
  endtask

  // Called just after a falling edge with inputs set; checks then advances one cycle.
  task automatic step(input string tag);
    bit s;
    #1;
    exp_v = model(s);
    obs = {bus.pc_en, bus.en_ifid, bus.en_idex, bus.en_exmem, bus.en_memwb,
           bus.clr_ifid, bus.clr_idex, bus.clr_exmem, bus.clr_memwb,
           bus.md_start, bus.md_busy};
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
    end
    if (s) busy_end = cyc + ((bus.ex_md_op == 2'd1) ? MULT_N : DIV_N);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    set_idle();
    reset = 1'b0;
    @(negedge clk);
    step("reset_idle");
    reset = 1'b1;
    step("idle");

    // load-use: one bubble, then normal
    bus.ex_load = 1; bus.ex_reg_write = 1; bus.ex_wr_reg = 8; bus.id_rs = 8; bus.id_use_rs = 1;
    step("load_use_stall");
    set_idle(); bus.id_rs = 8; bus.id_use_rs = 1;
    step("load_use_release");

    // div in EX with an mflo waiting in ID
    set_idle(); bus.ex_md_op = 2'd2; bus.id_md_use = 1;
    step("div_start");
    bus.ex_md_op = 2'd0;
    for (int i = 0; i < DIV_N; i++) step("div_wait");
    step("div_release");

    // branch depending on a load: EX match, then MEM match
    set_idle(); bus.id_branch = 1; bus.id_rt = 9;
    bus.ex_load = 1; bus.ex_reg_write = 1; bus.ex_wr_reg = 9;
    step("br_ld_ex");
    bus.ex_load = 0; bus.ex_reg_write = 0; bus.ex_wr_reg = 0;
    bus.mem_load = 1; bus.mem_wr_reg = 9;
    step("br_ld_mem");
    bus.mem_load = 0; bus.mem_wr_reg = 0;
    step("br_ld_release");

    // exception during load-use stall, mult in EX suppressed
    set_idle(); bus.ex_load = 1; bus.ex_wr_reg = 8; bus.id_rs = 8; bus.id_use_rs = 1;
    bus.mem_exc = 1; bus.ex_md_op = 2'd1;
    step("exc_over_stall");

    // $0 never a hazard
    set_idle(); bus.ex_load = 1; bus.ex_wr_reg = 0; bus.id_rs = 0; bus.id_use_rs = 1;
    bus.id_branch = 1; bus.ex_reg_write = 1;
    step("reg0_immune");

    // reset in the middle of a mult
    set_idle(); bus.ex_md_op = 2'd1;
    step("mult_start");
    bus.ex_md_op = 2'd0;
    for (int i = 0; i < 2; i++) step("mult_busy");
    #2;
    reset = 1'b0;
    #1;
    tests++;
    assert (bus.md_busy === 1'b0) else begin
      fails++;
      $error("FAIL async_reset_busy observed=%b expected=0", bus.md_busy);
    end
    busy_end = -1;
    @(negedge clk);
    cyc++;
    reset = 1'b1;
    step("post_reset_idle");
    bus.ex_md_op = 2'd1;
    step("mult_after_reset");
    bus.ex_md_op = 2'd0;
    for (int i = 0; i < MULT_N; i++) step("mult_after_reset_busy");
    step("mult_after_reset_done");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus.id_rs        = 5'($urandom_range(0, 3));
      bus.id_rt        = 5'($urandom_range(0, 3));
      bus.id_use_rs    = 1'($urandom);
      bus.id_use_rt    = 1'($urandom);
      bus.id_branch    = ($urandom_range(0, 3) == 0);
      bus.id_md_use    = ($urandom_range(0, 3) == 0);
      bus.ex_reg_write = 1'($urandom);
      bus.ex_load      = 1'($urandom);
      bus.ex_wr_reg    = 5'($urandom_range(0, 3));
      bus.mem_load     = 1'($urandom);
      bus.mem_wr_reg   = 5'($urandom_range(0, 3));
      bus.ex_md_op     = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'd0;
      bus.mem_exc      = ($urandom_range(0, 9) == 0);
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
